// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core
// load/store path (requester 0) and the debug/loader port (requester 1).
module data_memory_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req_0,
    input  logic                  we_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic                  req_1,
    input  logic                  we_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,

    output logic                  gnt_0,
    output logic                  gnt_1,
    output logic                  done_0,
    output logic                  done_1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,

    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  prio_q, prio_d;
    logic                  cmd_we_q, cmd_we_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            done_q, done_d;

    logic any_req;
    logic winner;

    assign any_req = req_0 | req_1;
    // A lone requester always wins; a tie goes to the requester holding priority.
    assign winner  = (req_0 & req_1) ? prio_q : req_1;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata_d     = rdata_q;
        gnt_d       = 2'b00;
        done_d      = 2'b00;

        case (state_q)
            StIdle, StResp: begin
                if (any_req) begin
                    state_d         = StAccess;
                    owner_d         = winner;
                    prio_d          = ~winner;
                    gnt_d[winner]   = 1'b1;
                    cmd_we_d        = winner ? we_1    : we_0;
                    cmd_addr_d      = winner ? addr_1  : addr_0;
                    cmd_wdata_d     = winner ? wdata_1 : wdata_0;
                end else begin
                    state_d = StIdle;
                end
            end
            StAccess: begin
                state_d         = StResp;
                done_d[owner_q] = 1'b1;
                if (!cmd_we_q) begin
                    rdata_d = mem_read_data;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            prio_q      <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata_q     <= '0;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata_q     <= rdata_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
        end
    end

    assign gnt_0  = gnt_q[0];
    assign gnt_1  = gnt_q[1];
    assign done_0 = done_q[0];
    assign done_1 = done_q[1];
    assign rdata  = rdata_q;
    assign busy   = (state_q == StAccess) || (state_q == StResp);

    // Address and write data simply follow the latched command; only the enables qualify them.
    assign mem_read_enable  = (state_q == StAccess) & ~cmd_we_q;
    assign mem_write_enable = (state_q == StAccess) &  cmd_we_q;
    assign mem_address      = cmd_addr_q;
    assign mem_write_data   = cmd_wdata_q;

endmodule
